fifo_uart_tx: RTL
=================

// Module: fifo_uart_tx
// PURPOSE
//  Read-side consumer of the byte FIFO: pops bytes whenever the FIFO is non-empty and serialises each
//  as an 8N1 UART frame (LSB first) on a single TX pin. Sits between the FIFO (enq side fed by
//  upstream logic) and the board UART TX pad, closing the host-bound data path.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency, Hz
//  BAUD       115_200      line rate, bit/s
//  (local) CLKS_PER_BIT = CLK_HZ/BAUD (integer division); counter width = $clog2(CLKS_PER_BIT)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  asynchronous, active-low reset
//  fifo_empty  in   1  FIFO empty flag
//  fifo_dout   in   8  FIFO head byte, valid combinationally whenever fifo_empty=0 (first-word fall-through)
//  fifo_deq    out  1  one-cycle pop strobe to FIFO deq
//  tx          out  1  UART serial output, idle high
//  busy        out  1  high while a frame is in progress (any state except IDLE)
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, tx=1, fifo_deq=0, busy=0, bit/baud counters=0, shift reg=0.
//    Reset mid-frame aborts: tx goes high immediately; the in-flight byte is lost, never re-read.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs registered.
//  - IDLE: tx=1. If fifo_empty=0: latch fifo_dout into shift reg, fifo_deq=1 for exactly this cycle,
//    go START. If fifo_empty=1: stay, fifo_deq=0.
//  - START: tx=0 for CLKS_PER_BIT cycles (tx falls the cycle after the deq strobe).
//  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit index 0..7, shift right per bit.
//  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
//  - Baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 on every state/bit advance.
//  - Frame = 10*CLKS_PER_BIT cycles (11* with parity); busy high for exactly that span.
//  - Back-to-back: exactly one IDLE cycle (tx=1) between consecutive frames when FIFO stays non-empty.
//  - fifo_deq is never asserted while fifo_empty=1 nor outside IDLE; at most one pop per frame.
//  - fifo_empty/fifo_dout changes during a frame are ignored; data is taken only at the pop cycle.
//  - Elaboration: CLKS_PER_BIT < 2 is a fatal error ($error in generate check).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state inserted after DATA; tx = even parity (XOR of the 8 data
//    bits) for CLKS_PER_BIT cycles; frame 11*CLKS_PER_BIT cycles (8E1).
//  Not defined: no PARITY state, no parity logic; DATA -> STOP directly (8N1).
// TESTING (CLK_HZ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10; FIFO model with FWFT head)
//  1 Reset with FIFO empty, release, run 50 cyc -> tx=1, busy=0, fifo_deq=0 throughout.
//  2 Load 0xA5 -> one fifo_deq pulse; tx=0 10 cyc, then bits 1,0,1,0,0,1,0,1 x10 cyc, stop=1 10 cyc;
//    busy high exactly 100 cyc; sampled byte at bit centres == 0xA5.
//  3 Load 0x00,0xFF,0x55 -> three deq pulses 101 cyc apart; exactly one idle-high cycle between frames;
//    decoded bytes in order; fifo_empty=1 afterwards and no further deq.
//  4 Load 0x3C,0x81; assert reset during data bit 3 of 0x3C -> tx=1 same cycle (async), busy=0;
//    after release next deq pops 0x81 and it is sent intact; 0x3C never retransmitted.
//  5 Toggle fifo_empty/fifo_dout randomly mid-frame of 0xC3 -> transmitted byte still 0xC3, no deq
//    until following IDLE cycle.
//  6 With UART_TX_PARITY_EN: 0xA5 -> parity bit 0; 0x07 -> parity bit 1; frame 110 cyc, busy 110 cyc.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Purpose : pops bytes from a first-word-fall-through FIFO and serialises each one as a UART frame
//           (8N1 by default, 8E1 when UART_TX_PARITY_EN is defined), LSB first, on a single TX pin.
// Latency : fifo_deq pulses one cycle after the FIFO is seen non-empty; tx falls the cycle after that pulse.
// Backpressure: pops only from IDLE, so at most one byte is in flight; the FIFO simply holds data while busy.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   fifo_empty - FIFO empty flag
//   fifo_dout  - FIFO head byte (valid whenever fifo_empty=0)
//   fifo_deq   - one-cycle pop strobe to the FIFO
//   tx         - UART serial output, idle high
//   busy       - high for the whole frame on tx
//
// Configuration macro: UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
// All outputs are registered, so tx/busy show the state of the previous cycle: the pop cycle itself
// still shows tx=1/busy=0, which is also the single idle-high cycle between back-to-back frames.

module fifo_uart_tx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_deq,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("fifo_uart_tx: CLK_HZ/BAUD must be at least 2");
        end
    endgenerate

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
`ifdef UART_TX_PARITY_EN
    logic            par_bit;
`endif

    logic baud_done;
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            fifo_deq <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            fifo_deq <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (!fifo_empty) begin
                        // FWFT head is valid now; capture it together with the pop.
                        shreg    <= fifo_dout;
                        fifo_deq <= 1'b1;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= S_START;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= ^fifo_dout;
`endif
                    end
                end

                S_START: begin
                    tx   <= 1'b0;
                    busy <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    tx   <= shreg[0];
                    busy <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        shreg    <= {1'b0, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= S_PARITY;
`else
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    tx   <= par_bit;
                    busy <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    tx   <= 1'b1;
                    busy <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
